// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, field offsets and BCD helpers for the RTC
package rtc_pkg;

    localparam logic [3:0] SEC_L_MAX     = 4'd9;
    localparam logic [3:0] SEC_M_MAX     = 4'd5;
    localparam logic [3:0] MIN_L_MAX     = 4'd9;
    localparam logic [3:0] MIN_M_MAX     = 4'd5;
    localparam logic [3:0] HR_L_MAX      = 4'd9;
    localparam logic [3:0] HR_M_MAX      = 4'd2;
    localparam logic [3:0] HR_L_MAX_AT_2 = 4'd3;

    // Packed 24-bit time {hrm,hrl,minm,minl,secm,secl}
    localparam int T_HRM  = 20;
    localparam int T_HRL  = 16;
    localparam int T_MINM = 12;
    localparam int T_MINL = 8;
    localparam int T_SECM = 4;
    localparam int T_SECL = 0;

    // Packed 16-bit alarm {hrm,hrl,minm,minl}
    localparam int A_HRM  = 12;
    localparam int A_HRL  = 8;
    localparam int A_MINM = 4;
    localparam int A_MINL = 0;

    // True when every digit is in range and the hour is at most 23
    function automatic logic time_valid(input logic [23:0] t);
        logic [3:0] hm;
        logic [3:0] hl;
        hm = t[T_HRM +: 4];
        hl = t[T_HRL +: 4];
        return (hm <= HR_M_MAX) && (hl <= HR_L_MAX) &&
               !((hm == HR_M_MAX) && (hl > HR_L_MAX_AT_2)) &&
               (t[T_MINM +: 4] <= MIN_M_MAX) && (t[T_MINL +: 4] <= MIN_L_MAX) &&
               (t[T_SECM +: 4] <= SEC_M_MAX) && (t[T_SECL +: 4] <= SEC_L_MAX);
    endfunction

    // Value a digit counter will hold after an advance edge
    function automatic logic [3:0] bcd_next(input logic [3:0] c, input logic en,
                                            input logic wrap);
        if (wrap)
            return 4'd0;
        else if (en)
            return c + 4'd1;
        else
            return c;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit with load, enable and dynamic limit
module bcd_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic [3:0] max_dyn,
    output logic [3:0] count,
    output logic       wrap
);

    logic [3:0] lim;
    logic [3:0] count_d;
    logic [3:0] count_q;

    // Effective limit: the runtime limit, never above the static one
    always_comb begin
        lim = (max_dyn > MAX) ? MAX : max_dyn;
    end

    assign wrap  = en && (count_q >= lim);
    assign count = count_q;

    // Load beats count; counting wraps to zero at the limit
    always_comb begin
        count_d = count_q;
        if (ld)
            count_d = ld_val;
        else if (en)
            count_d = wrap ? 4'd0 : count_q + 4'd1;
    end

    // Digit register
    always_ff @(posedge clk) begin
        if (!rst)
            count_q <= 4'd0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/rtc_bcd_alarm.sv
// rtl/rtc_bcd_alarm.sv - BCD real-time clock with set port, 12/24h display and alarm
module rtc_bcd_alarm
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int DIV_W    = $clog2(TICK_DIV)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode12,
    input  logic        set_en,
    input  logic [23:0] set_time,
    input  logic        alarm_wr,
    input  logic [15:0] alarm_time,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    output logic [3:0]  hrm,
    output logic [3:0]  hrl,
    output logic [3:0]  minm,
    output logic [3:0]  minl,
    output logic [3:0]  secm,
    output logic [3:0]  secl,
    output logic        pm,
    output logic        sec_tick,
    output logic        alarm,
    output logic        set_err
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_d, div_q;
    logic [15:0]      alm_d, alm_q;
    logic             sec_tick_d, sec_tick_q;
    logic             alarm_d, alarm_q;
    logic             set_err_d, set_err_q;

    logic set_ok, alm_ok, tick, adv, fire;
    logic [3:0] secl_c, secm_c, minl_c, minm_c, hrl_c, hrm_c;
    logic secl_w, secm_w, minl_w, minm_w, hrl_w, hrm_w;
    logic [3:0] hrl_max;
    logic [23:0] next_time;

    assign set_ok  = set_en && time_valid(set_time);
    assign alm_ok  = alarm_wr && time_valid({alarm_time, 8'h00});
    assign tick    = (div_q == DIV_MAX);
    assign adv     = tick && !set_ok;
    assign hrl_max = (hrm_c == HR_M_MAX) ? HR_L_MAX_AT_2 : HR_L_MAX;

    bcd_digit_counter #(.MAX(SEC_L_MAX)) u_secl (
        .clk(clk), .rst(rst), .en(adv), .ld(set_ok),
        .ld_val(set_time[T_SECL +: 4]), .max_dyn(SEC_L_MAX),
        .count(secl_c), .wrap(secl_w));

    bcd_digit_counter #(.MAX(SEC_M_MAX)) u_secm (
        .clk(clk), .rst(rst), .en(secl_w), .ld(set_ok),
        .ld_val(set_time[T_SECM +: 4]), .max_dyn(SEC_M_MAX),
        .count(secm_c), .wrap(secm_w));

    bcd_digit_counter #(.MAX(MIN_L_MAX)) u_minl (
        .clk(clk), .rst(rst), .en(secm_w), .ld(set_ok),
        .ld_val(set_time[T_MINL +: 4]), .max_dyn(MIN_L_MAX),
        .count(minl_c), .wrap(minl_w));

    bcd_digit_counter #(.MAX(MIN_M_MAX)) u_minm (
        .clk(clk), .rst(rst), .en(minl_w), .ld(set_ok),
        .ld_val(set_time[T_MINM +: 4]), .max_dyn(MIN_M_MAX),
        .count(minm_c), .wrap(minm_w));

    bcd_digit_counter #(.MAX(HR_L_MAX)) u_hrl (
        .clk(clk), .rst(rst), .en(minm_w), .ld(set_ok),
        .ld_val(set_time[T_HRL +: 4]), .max_dyn(hrl_max),
        .count(hrl_c), .wrap(hrl_w));

    bcd_digit_counter #(.MAX(HR_M_MAX)) u_hrm (
        .clk(clk), .rst(rst), .en(hrl_w), .ld(set_ok),
        .ld_val(set_time[T_HRM +: 4]), .max_dyn(HR_M_MAX),
        .count(hrm_c), .wrap(hrm_w));

    // Time the counters will hold after this edge if it is an advance
    always_comb begin
        next_time = {bcd_next(hrm_c, hrl_w, hrm_w),
                     bcd_next(hrl_c, minm_w, hrl_w),
                     bcd_next(minm_c, minl_w, minm_w),
                     bcd_next(minl_c, secm_w, minl_w),
                     bcd_next(secm_c, secl_w, secm_w),
                     bcd_next(secl_c, adv, secl_w)};
        fire = adv && alarm_en && (next_time == {alm_q, 8'h00});
    end

    // Prescaler, alarm register, flags: next-state
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (set_ok || tick)
            div_d = '0;
        alm_d = alm_ok ? alarm_time : alm_q;
        alarm_d = alarm_q;
        if (fire)
            alarm_d = 1'b1;
        else if (alarm_ack)
            alarm_d = 1'b0;
        sec_tick_d = adv;
        set_err_d  = (set_en && !set_ok) || (alarm_wr && !alm_ok);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q      <= '0;
            alm_q      <= 16'h0000;
            alarm_q    <= 1'b0;
            sec_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            alm_q      <= alm_d;
            alarm_q    <= alarm_d;
            sec_tick_q <= sec_tick_d;
            set_err_q  <= set_err_d;
        end
    end

    assign sec_tick = sec_tick_q;
    assign alarm    = alarm_q;
    assign set_err  = set_err_q;
    assign minm     = minm_c;
    assign minl     = minl_c;
    assign secm     = secm_c;
    assign secl     = secl_c;

    // Hour display: 24h pass-through or 12h remap of the stored hour
    always_comb begin
        hrm = hrm_c;
        hrl = hrl_c;
        pm  = (hrm_c == 4'd2) || ((hrm_c == 4'd1) && (hrl_c >= 4'd2));
        if (mode12) begin
            if ((hrm_c == 4'd0) && (hrl_c == 4'd0)) begin
                hrm = 4'd1;
                hrl = 4'd2;
            end else if ((hrm_c == 4'd1) && (hrl_c >= 4'd3)) begin
                hrm = 4'd0;
                hrl = hrl_c - 4'd2;
            end else if ((hrm_c == 4'd2) && (hrl_c <= 4'd1)) begin
                hrm = 4'd0;
                hrl = hrl_c + 4'd8;
            end else if (hrm_c == 4'd2) begin
                hrm = 4'd1;
                hrl = hrl_c - 4'd2;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bcd_alarm.sv
// tb/tb_rtc_bcd_alarm.sv - scoreboard bench for rtc_bcd_alarm
module tb_rtc_bcd_alarm;

    localparam int TD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode12, set_en, alarm_wr, alarm_en, alarm_ack;
    logic [23:0] set_time;
    logic [15:0] alarm_time;
    logic [3:0]  hrm, hrl, minm, minl, secm, secl;
    logic        pm, sec_tick, alarm, set_err;

    int total = 0;
    int bad   = 0;
    logic [27:0] sb_q[$];

    int   m_time, m_div, m_alm;
    logic m_alarm, m_tick, m_err;

    rtc_bcd_alarm #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .mode12(mode12), .set_en(set_en), .set_time(set_time),
        .alarm_wr(alarm_wr), .alarm_time(alarm_time), .alarm_en(alarm_en),
        .alarm_ack(alarm_ack), .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl),
        .secm(secm), .secl(secl), .pm(pm), .sec_tick(sec_tick), .alarm(alarm),
        .set_err(set_err));

    function automatic int dec_time(input logic [23:0] t);
        return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
               (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
               int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic bit valid_t(input logic [23:0] t);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++)
            if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
        if (int'(t[23:20]) * 10 + int'(t[19:16]) > 23) ok = 1'b0;
        if (t[15:12] > 4'd5) ok = 1'b0;
        if (t[7:4] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [27:0] disp(input int s, input logic m12, input logic tk,
                                         input logic al, input logic er);
        int h, mi, se, dh;
        h  = s / 3600;
        mi = (s / 60) % 60;
        se = s % 60;
        dh = h;
        if (m12) dh = (h % 12 == 0) ? 12 : h % 12;
        return {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10),
                (h >= 12) ? 1'b1 : 1'b0, tk, al, er};
    endfunction

    function automatic logic [27:0] obs();
        return {hrm, hrl, minm, minl, secm, secl, pm, sec_tick, alarm, set_err};
    endfunction

    task automatic compare(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock: model the edge, queue the expectation, then pop and compare
    task automatic cyc(input string tag);
        bit set_ok, alm_ok, adv, fire;
        int nt;
        logic [27:0] e;
        if (!rst) begin
            m_time = 0; m_div = 0; m_alm = 0;
            m_alarm = 1'b0; m_tick = 1'b0; m_err = 1'b0;
        end else begin
            set_ok = set_en && valid_t(set_time);
            alm_ok = alarm_wr && valid_t({alarm_time, 8'h00});
            adv    = (m_div == TD - 1) && !set_ok;
            nt     = set_ok ? dec_time(set_time) : (adv ? (m_time + 1) % 86400 : m_time);
            fire   = adv && alarm_en && (nt == m_alm * 60);
            m_err  = (set_en && !set_ok) || (alarm_wr && !alm_ok);
            m_alarm = fire ? 1'b1 : (alarm_ack ? 1'b0 : m_alarm);
            if (alm_ok) m_alm = dec_time({alarm_time, 8'h00}) / 60;
            m_div  = (set_ok || m_div == TD - 1) ? 0 : m_div + 1;
            m_tick = adv;
            m_time = nt;
        end
        sb_q.push_back(disp(m_time, mode12, m_tick, m_alarm, m_err));
        @(posedge clk);
        #1;
        set_en = 1'b0; alarm_wr = 1'b0; alarm_ack = 1'b0;
        e = sb_q.pop_front();
        compare(tag, {4'h0, obs()}, {4'h0, e});
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    // Combinational check between edges (mode12 changes)
    task automatic comb(input string tag);
        logic [27:0] e;
        #1;
        sb_q.push_back(disp(m_time, mode12, m_tick, m_alarm, m_err));
        e = sb_q.pop_front();
        compare(tag, {4'h0, obs()}, {4'h0, e});
    endtask

    task automatic do_set(input logic [23:0] t, input string tag);
        set_en = 1'b1; set_time = t;
        cyc(tag);
    endtask

    initial begin
        rst = 1'b0; mode12 = 1'b0; set_en = 1'b0; set_time = 24'h0;
        alarm_wr = 1'b0; alarm_time = 16'h0; alarm_en = 1'b0; alarm_ack = 1'b0;
        m_time = 0; m_div = 0; m_alm = 0; m_alarm = 1'b0; m_tick = 1'b0; m_err = 1'b0;

        run(2, "reset");
        mode12 = 1'b1; comb("reset_m12");
        mode12 = 1'b0; comb("reset_m24");

        rst = 1'b1;
        run(TD - 1, "first_wait");
        compare("first_secl0", {28'h0, secl}, 32'h0);
        cyc("first_adv");
        compare("first_secl1", {28'h0, secl}, 32'h1);
        run(240 - TD, "count");
        compare("one_min", {16'h0, minm, minl, secm, secl}, 32'h0100);

        do_set(24'h235958, "set_2358");
        run(2 * TD, "roll_day");
        compare("midnight", {8'h0, hrm, hrl, minm, minl, secm, secl}, 32'h000000);
        do_set(24'h095959, "set_0959");
        run(TD, "roll_10");
        compare("roll_10h", {24'h0, hrm, hrl}, 32'h10);
        do_set(24'h195959, "set_1959");
        run(TD, "roll_20");
        compare("roll_20h", {24'h0, hrm, hrl}, 32'h20);

        run(1, "pre_bad");
        do_set(24'h240000, "bad_24");
        compare("err_24", {31'h0, set_err}, 32'h1);
        cyc("bad_24_after");
        do_set(24'h126000, "bad_60");
        do_set(24'h1A0000, "bad_1A");
        run(TD + 1, "bad_run");

        mode12 = 1'b1;
        do_set(24'h000000, "m12_00");
        do_set(24'h115900, "m12_11");
        do_set(24'h120000, "m12_12");
        do_set(24'h130000, "m12_13");
        compare("m12_13_disp", {23'h0, hrm, hrl, pm}, {23'h0, 4'h0, 4'h1, 1'b1});
        mode12 = 1'b0; comb("m12_off");
        mode12 = 1'b1; comb("m12_on");
        run(2, "m12_run");
        mode12 = 1'b0;

        alarm_en = 1'b1;
        alarm_wr = 1'b1; alarm_time = 16'h2400;
        cyc("alm_bad");
        alarm_wr = 1'b1; alarm_time = 16'h0730;
        cyc("alm_wr");
        do_set(24'h072959, "alm_set");
        run(TD, "alm_fire");
        compare("alm_fired", {31'h0, alarm}, 32'h1);
        run(3, "alm_hold");
        alarm_ack = 1'b1; cyc("alm_ack");
        do_set(24'h073000, "alm_direct");
        run(TD + 1, "alm_direct_run");
        compare("alm_direct_quiet", {31'h0, alarm}, 32'h0);
        do_set(24'h072959, "alm_set2");
        run(TD - 1, "alm_pre");
        alarm_ack = 1'b1; cyc("alm_fire_ack");
        compare("fire_beats_ack", {31'h0, alarm}, 32'h1);
        alarm_ack = 1'b1; cyc("alm_ack2");
        alarm_en = 1'b0;
        do_set(24'h072959, "alm_dis_set");
        run(TD + 1, "alm_dis");
        compare("alm_dis_quiet", {31'h0, alarm}, 32'h0);

        alarm_en = 1'b1;
        do_set(24'h072959, "alm_set3");
        run(TD + 2, "alm_mid");
        rst = 1'b0; set_en = 1'b1; set_time = 24'h120000;
        cyc("rst_mid");
        compare("rst_mid_vals", {4'h0, obs()}, 32'h0);
        rst = 1'b1;
        run(TD - 1, "rst_wait");
        compare("rst_secl0", {28'h0, secl}, 32'h0);
        cyc("rst_adv");
        compare("rst_secl1", {28'h0, secl}, 32'h1);
        run(2, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_bcd_alarm.md
# rtc_bcd_alarm

Parametrised successor to the team's BCD real-time clock. It keeps hh:mm:ss as six BCD digits, advanced by an internal one-second prescaler running as a clock enable on the single system clock (no derived clocks). It adds a synchronous time-set load port, a runtime 12/24-hour display mode and one hh:mm alarm with a sticky flag. It sits between the board clock and the display/driver logic.

## Interface
- TICK_DIV, 100000000, clk cycles per second; must be ≥ 2 (benches use small values such as 4).
- DIV_W, $clog2(TICK_DIV), prescaler width (derived; do not override).
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low: rst==0 at a posedge resets the block.
- mode12  input  1  1 = 12-hour display, 0 = 24-hour display; affects outputs only, not the stored time.
- set_en  input  1  one-cycle strobe: load set_time.
- set_time  input  24  BCD {hrm,hrl,minm,minl,secm,secl}, always 24-hour format.
- alarm_wr  input  1  one-cycle strobe: load alarm_time.
- alarm_time  input  16  BCD {hrm,hrl,minm,minl}, 24-hour format.
- alarm_en  input  1  arms the alarm comparison.
- alarm_ack  input  1  clears the alarm flag.
- hrm, hrl, minm, minl, secm, secl  output  4 each  displayed time digits.
- pm  output  1  1 when the stored hour ≥ 12; valid in both modes.
- sec_tick  output  1  one-cycle pulse, one cycle after each seconds advance.
- alarm  output  1  sticky alarm flag.
- set_err  output  1  one-cycle pulse: a set or alarm write was rejected.

## Operation
- Stored time is 24-hour BCD. Digit limits: secl/minl 0–9; secm/minm 0–5; hrl 0–9, or 0–3 when hrm==2; hrm 0–2.
- Carry chain: secl wraps 9→0 and enables secm. The chain continues through 59 s, then 59 min. Hour rollover is 23:59:59 → 00:00:00; 09→10 and 19→20 carry normally.
- Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the time advances by one second in the same edge.
- set_en: the time loads only if every digit is within its limit and the hour is ≤ 23. Otherwise the time is unchanged and set_err pulses.
- A valid set also clears the prescaler to 0.
- alarm_wr: the same validity rule applies, with the hour ≤ 23 and minutes ≤ 59. Invalid writes pulse set_err and keep the old alarm value.
- Alarm fires, i.e. alarm is set to 1, when all of the following hold:
  - a seconds advance (not a set) produces a time equal to alarm_time:00;
  - alarm_en==1.
- alarm stays 1 until alarm_ack.
- A set that lands exactly on the alarm time does not fire.
- 12-hour display is a combinational mapping of the stored hour, with pm from the stored hour:
  - 00 → 12 (pm=0);
  - 01–11 unchanged (pm=0);
  - 12 → 12 (pm=1);
  - 13–23 → 01–11 (pm=1).
- Minutes and seconds are never remapped.
- Priority per edge:
  - rst, over everything else;
  - set_en, over a tick;
  - tick.
- alarm_wr is independent of set_en and can occur in the same cycle.
- Same cycle fire and alarm_ack: the fire wins and alarm stays 1.

## Timing
- Reset values:
  - time 00:00:00, prescaler 0, alarm register 00:00;
  - alarm=0, sec_tick=0, set_err=0;
  - display 00:00:00 with pm=0 in 24-hour mode, 12:00:00 with pm=0 in 12-hour mode.
- Reset mid-operation discards any pending set, tick or alarm state.
- First advance: secl=1 is visible after the posedge that is the TICK_DIV-th edge following the first edge with rst==1.
- Set latency: 1 cycle. set_time is visible on outputs right after the sampling edge; the next advance comes TICK_DIV edges later.
- sec_tick: registered, high for exactly one cycle in the cycle after the time changes.
- alarm: rises on the same edge as the matching advance.
- set_err: high for the one cycle after the rejected strobe.
- mode12 change: outputs update combinationally in the same cycle; no state changes.

## Structure
- Shared package rtc_pkg holds:
  - digit limit constants (SEC_L_MAX=9, SEC_M_MAX=5, HR_M_MAX=2, HR_L_MAX_AT_2=3);
  - the packed 24-bit time and 16-bit alarm field offsets;
  - a BCD-time validity function used by both the set and alarm-write paths.
- One sub-module, bcd_digit_counter:
  - parameter MAX;
  - inputs clk, rst, en, ld, ld_val, max_dyn (for the hrl 3/9 limit);
  - outputs count and wrap.
- Six instances of bcd_digit_counter. The prescaler, alarm compare and 12-hour mapping live in the top.

## Test plan
- TICK_DIV=4, reset released → secl increments every 4 cycles; sec_tick pulses one cycle after each increment; after 60 s, minl=1 and secs=00.
- set 23:59:58, run 2 s → 23:59:59, then 00:00:00. Also set 09:59:59 → 10:00:00, and 19:59:59 → 20:00:00.
- set 24:00:00, 12:60:00 and 1A:00:00 → each pulses set_err for 1 cycle; time unchanged; prescaler not cleared.
- mode12=1 with the stored hour at 00, 11, 12 and 13 → display 12/11/12/01 with pm 0/0/1/1; toggling mode12 leaves the stored time intact.
- Alarm:
  - alarm 07:30, alarm_en=1, set 07:29:59, 1 s → alarm=1 on the 07:30:00 edge;
  - the flag holds until alarm_ack;
  - set 07:30:00 directly → no fire;
  - alarm_en=0 → no fire.
- rst=0 asserted mid-count with alarm=1 and a set_en in the same cycle → next cycle shows all outputs at reset values and the set ignored; the advance after reset takes a full TICK_DIV cycles.
